// File: rtl/bus_xfer_ctrl.sv
// Two-state command sequencer driving load/enable strobes of a bank of register_2oe cells.
// Optional completed-transfer counter is built when BUS_XFER_CTRL_XFER_CNT_EN is defined.
module bus_xfer_ctrl #(
    parameter int NREG  = 4,
    parameter int IDX_W = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [IDX_W-1:0] cmd_src,
    input  logic [IDX_W-1:0] cmd_src2,
    input  logic [IDX_W-1:0] cmd_dst,
    output logic [NREG-1:0]  load,
    output logic [NREG-1:0]  enable1,
    output logic [NREG-1:0]  enable2,
    output logic             ext_drive,
    output logic             done,
`ifdef BUS_XFER_CTRL_XFER_CNT_EN
    output logic             err,
    output logic [15:0]      xfer_count
`else
    output logic             err
`endif
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] EXEC = 1'b1;

    localparam logic [1:0] OP_NOP   = 2'b00;
    localparam logic [1:0] OP_MOVE  = 2'b01;
    localparam logic [1:0] OP_WRITE = 2'b10;
    localparam logic [1:0] OP_READ2 = 2'b11;

    logic [0:0]      state_q, state_d;
    logic [NREG-1:0] load_q, load_d;
    logic [NREG-1:0] en1_q, en1_d;
    logic [NREG-1:0] en2_q, en2_d;
    logic            ext_q, ext_d;
    logic            done_q, done_d;
    logic            err_q, err_d;

    logic srcOk, src2Ok, dstOk;

    function automatic logic [NREG-1:0] oneHot(input logic [IDX_W-1:0] idx);
        return {{(NREG-1){1'b0}}, 1'b1} << idx;
    endfunction

    assign srcOk  = int'(cmd_src)  < NREG;
    assign src2Ok = int'(cmd_src2) < NREG;
    assign dstOk  = int'(cmd_dst)  < NREG;

    // Strobes are decoded at acceptance and registered, so they appear exactly in the EXEC cycle.
    always_comb begin
        state_d = state_q;
        load_d  = '0;
        en1_d   = '0;
        en2_d   = '0;
        ext_d   = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    state_d = EXEC;
                    done_d  = 1'b1;
                    case (cmd_op)
                        OP_NOP: ;
                        OP_MOVE: begin
                            if (!srcOk || !dstOk) begin
                                err_d = 1'b1;
                            end else if (cmd_src != cmd_dst) begin
                                en1_d  = oneHot(cmd_src);
                                load_d = oneHot(cmd_dst);
                            end
                        end
                        OP_WRITE: begin
                            if (!dstOk) begin
                                err_d = 1'b1;
                            end else begin
                                ext_d  = 1'b1;
                                load_d = oneHot(cmd_dst);
                            end
                        end
                        OP_READ2: begin
                            if (!srcOk || !src2Ok) begin
                                err_d = 1'b1;
                            end else begin
                                en1_d = oneHot(cmd_src);
                                en2_d = oneHot(cmd_src2);
                            end
                        end
                        default: ;
                    endcase
                end
            end
            EXEC:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            load_q  <= '0;
            en1_q   <= '0;
            en2_q   <= '0;
            ext_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            load_q  <= load_d;
            en1_q   <= en1_d;
            en2_q   <= en2_d;
            ext_q   <= ext_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign load      = load_q;
    assign enable1   = en1_q;
    assign enable2   = en2_q;
    assign ext_drive = ext_q;
    assign done      = done_q;
    assign err       = err_q;

`ifdef BUS_XFER_CTRL_XFER_CNT_EN
    logic [15:0] cnt_q;

    // Counts at the end of each successful EXEC cycle; NOPs count too, wrap is natural.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (done_q && !err_q) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign xfer_count = cnt_q;
`endif

endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// Self-checking bench for bus_xfer_ctrl: one NREG=4 and one NREG=3 instance share stimulus
// and are compared every cycle against a command-level reference model.
module tb_bus_xfer_ctrl;

    typedef struct packed {
        logic [15:0] load;
        logic [15:0] en1;
        logic [15:0] en2;
        logic        ext;
        logic        done;
        logic        err;
        logic        ready;
    } exp_t;

    logic       clock;
    logic       reset;
    logic       cmd_valid;
    logic [1:0] cmd_op;
    logic [1:0] cmd_src;
    logic [1:0] cmd_src2;
    logic [1:0] cmd_dst;

    logic       ready4, ext4, done4, err4;
    logic [3:0] load4, en1_4, en2_4;
    logic       ready3, ext3, done3, err3;
    logic [2:0] load3, en1_3, en2_3;
`ifdef BUS_XFER_CTRL_XFER_CNT_EN
    logic [15:0] cnt4, cnt3;
`endif

    int testCount = 0;
    int failCount = 0;
    exp_t exp4, exp3;
    int   expCnt4, expCnt3;

    bus_xfer_ctrl #(.NREG(4), .IDX_W(2)) dut4 (
        .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(ready4),
        .cmd_op(cmd_op), .cmd_src(cmd_src), .cmd_src2(cmd_src2), .cmd_dst(cmd_dst),
        .load(load4), .enable1(en1_4), .enable2(en2_4), .ext_drive(ext4),
        .done(done4),
`ifdef BUS_XFER_CTRL_XFER_CNT_EN
        .err(err4), .xfer_count(cnt4)
`else
        .err(err4)
`endif
    );

    bus_xfer_ctrl #(.NREG(3), .IDX_W(2)) dut3 (
        .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(ready3),
        .cmd_op(cmd_op), .cmd_src(cmd_src), .cmd_src2(cmd_src2), .cmd_dst(cmd_dst),
        .load(load3), .enable1(en1_3), .enable2(en2_3), .ext_drive(ext3),
        .done(done3),
`ifdef BUS_XFER_CTRL_XFER_CNT_EN
        .err(err3), .xfer_count(cnt3)
`else
        .err(err3)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Expected strobes for one accepted command, straight from the op rules.
    function automatic exp_t decode(input int nreg, input int op, input int s, input int s2, input int d);
        exp_t e;
        e = '0;
        e.done = 1'b1;
        case (op)
            1: begin
                if (s >= nreg || d >= nreg) e.err = 1'b1;
                else if (s != d) begin
                    e.en1  = 16'(1 << s);
                    e.load = 16'(1 << d);
                end
            end
            2: begin
                if (d >= nreg) e.err = 1'b1;
                else begin
                    e.ext  = 1'b1;
                    e.load = 16'(1 << d);
                end
            end
            3: begin
                if (s >= nreg || s2 >= nreg) e.err = 1'b1;
                else begin
                    e.en1 = 16'(1 << s);
                    e.en2 = 16'(1 << s2);
                end
            end
            default: ;
        endcase
        return e;
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        testCount++;
        assert (obs === expv) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic checkOutput();
        check("ready4", {15'b0, ready4}, {15'b0, exp4.ready});
        check("load4",  {12'b0, load4},  exp4.load);
        check("en1_4",  {12'b0, en1_4},  exp4.en1);
        check("en2_4",  {12'b0, en2_4},  exp4.en2);
        check("ext4",   {15'b0, ext4},   {15'b0, exp4.ext});
        check("done4",  {15'b0, done4},  {15'b0, exp4.done});
        check("err4",   {15'b0, err4},   {15'b0, exp4.err});
        check("ready3", {15'b0, ready3}, {15'b0, exp3.ready});
        check("load3",  {13'b0, load3},  exp3.load);
        check("en1_3",  {13'b0, en1_3},  exp3.en1);
        check("en2_3",  {13'b0, en2_3},  exp3.en2);
        check("ext3",   {15'b0, ext3},   {15'b0, exp3.ext});
        check("done3",  {15'b0, done3},  {15'b0, exp3.done});
        check("err3",   {15'b0, err3},   {15'b0, exp3.err});
        check("extExcl4", {15'b0, (ext4 & (|en1_4))}, 16'h0);
`ifdef BUS_XFER_CTRL_XFER_CNT_EN
        check("cnt4", cnt4, 16'(expCnt4));
        check("cnt3", cnt3, 16'(expCnt3));
`endif
    endtask

    // Advances the model one clock: the controller takes a command only when it was ready.
    function automatic exp_t nextExp(input exp_t cur, input int nreg, input bit v, input bit r,
                                     input int op, input int s, input int s2, input int d);
        exp_t n;
        n = '0;
        n.ready = 1'b1;
        if (!r && cur.ready && v) n = decode(nreg, op, s, s2, d);
        return n;
    endfunction

    task automatic applyStimulus(input bit v, input int op, input int s, input int s2,
                                 input int d, input bit r);
        reset     = r;
        cmd_valid = v;
        cmd_op    = 2'(op);
        cmd_src   = 2'(s);
        cmd_src2  = 2'(s2);
        cmd_dst   = 2'(d);
        @(posedge clock);
        if (r) begin
            expCnt4 = 0;
            expCnt3 = 0;
        end else begin
            if (exp4.done && !exp4.err) expCnt4 = (expCnt4 + 1) % 65536;
            if (exp3.done && !exp3.err) expCnt3 = (expCnt3 + 1) % 65536;
        end
        exp4 = nextExp(exp4, 4, v, r, op, s, s2, d);
        exp3 = nextExp(exp3, 3, v, r, op, s, s2, d);
        #1;
        checkOutput();
    endtask

    initial begin
        int doneSeen;
        exp4 = '0;
        exp3 = '0;
        expCnt4 = 0;
        expCnt3 = 0;

        applyStimulus(0, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 1);
        check("rstReady", {15'b0, ready4}, 16'h1);

        applyStimulus(1, 1, 1, 0, 3, 0);
        check("move13En1",  {12'b0, en1_4}, 16'b0010);
        check("move13Load", {12'b0, load4}, 16'b1000);
        applyStimulus(0, 0, 0, 0, 0, 0);

        applyStimulus(1, 2, 0, 0, 2, 0);
        check("wextLoad", {12'b0, load4}, 16'b0100);
        check("wextExt",  {15'b0, ext4},  16'h1);
        applyStimulus(0, 0, 0, 0, 0, 0);

        applyStimulus(1, 3, 0, 3, 0, 0);
        check("read2En2", {12'b0, en2_4}, 16'b1000);
        applyStimulus(0, 0, 0, 0, 0, 0);
        applyStimulus(1, 1, 2, 0, 2, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);

        applyStimulus(1, 1, 3, 0, 0, 0);
        check("badIdxErr3", {15'b0, err3}, 16'h1);
        applyStimulus(0, 0, 0, 0, 0, 0);
        applyStimulus(1, 3, 1, 3, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);

        doneSeen = 0;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1, 1, i % 4, 0, (i + 1) % 4, 0);
            if (done4) doneSeen++;
        end
        check("holdValidDones", 16'(doneSeen), 16'd3);
        applyStimulus(0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);

        applyStimulus(1, 1, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 1);
        check("abortDone", {15'b0, done4}, 16'h0);
        applyStimulus(0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 3) != 0, int'($urandom_range(0, 3)),
                          int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                          int'($urandom_range(0, 3)), $urandom_range(0, 39) == 0);
        end
        applyStimulus(0, 0, 0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
